// File: rtl/chi_txreq_arb.sv
// CHI TXREQ channel arbiter: round-robin grant across entry trackers, L-credit
// accounting, TX link activation FSM and credit return on deactivation.
module chi_txreq_arb #(
    parameter int NUM_ENTRIES = 4,
    parameter int MAX_CREDITS = 15,
    parameter int ADDR_W      = 48
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          link_en,
    input  logic [NUM_ENTRIES-1:0]        req_valid,
    output logic [NUM_ENTRIES-1:0]        req_ready,
    input  logic [NUM_ENTRIES*7-1:0]      req_opcode,
    input  logic [NUM_ENTRIES*ADDR_W-1:0] req_addr,
    output logic                          txreq_flitpend,
    output logic                          txreq_flitv,
    output logic [12+7+ADDR_W-1:0]        txreq_flit,
    input  logic                          txreq_lcrdv,
    output logic                          txlinkactivereq,
    input  logic                          txlinkactiveack,
    output logic [3:0]                    credit_cnt,
    output logic                          credit_ovf
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    localparam logic [1:0] ST_STOP     = 2'd0;
    localparam logic [1:0] ST_ACTIVATE = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_DEACT    = 2'd3;

    localparam logic [3:0] CRD_MAX = 4'(MAX_CREDITS);

    typedef struct packed {
        logic [11:0]       txnid;
        logic [6:0]        opcode;
        logic [ADDR_W-1:0] addr;
    } flit_t;

    logic [1:0]       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic             ovf;
    logic             flitv_q;
    flit_t            flit_q, flit_nxt;
    logic             areq_q;

    logic [NUM_ENTRIES-1:0][6:0]        opc_arr;
    logic [NUM_ENTRIES-1:0][ADDR_W-1:0] addr_arr;

    logic [IDX_W-1:0]       scan_idx, grant_idx;
    logic                   found;
    logic                   run_issue, ret_issue, issue;
    logic                   lcrd_acc, ovf_hit;
    logic [NUM_ENTRIES-1:0] grant_oh;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_unpack
        assign opc_arr[i]  = req_opcode[7*i +: 7];
        assign addr_arr[i] = req_addr[ADDR_W*i +: ADDR_W];
    end

    // Scan starts at rr_ptr; index arithmetic wraps because NUM_ENTRIES is 2^n.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            scan_idx = rr_ptr + IDX_W'(k);
            if (!found && req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign run_issue = (state == ST_RUN) && (cnt != 4'd0) && found;
    assign ret_issue = (state == ST_DEACT) && (cnt != 4'd0);
    assign issue     = run_issue || ret_issue;

    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = run_issue;
    end

    assign req_ready      = grant_oh;
    assign txreq_flitpend = issue;

    assign lcrd_acc = txreq_lcrdv && (state != ST_STOP);
    assign ovf_hit  = lcrd_acc && !issue && (cnt == CRD_MAX);

    always_comb begin
        cnt_nxt = cnt;
        case ({issue, lcrd_acc})
            2'b10:   cnt_nxt = cnt - 4'd1;
            2'b01:   cnt_nxt = ovf_hit ? cnt : cnt + 4'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Credit-return flits are all-zero: opcode ReqLCrdReturn, txnid 0, addr 0.
    always_comb begin
        flit_nxt = '0;
        if (run_issue) begin
            flit_nxt.txnid  = 12'(grant_idx);
            flit_nxt.opcode = opc_arr[grant_idx];
            flit_nxt.addr   = addr_arr[grant_idx];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP:     if (link_en)         state_nxt = ST_ACTIVATE;
            ST_ACTIVATE: if (txlinkactiveack) state_nxt = ST_RUN;
            ST_RUN:      if (!link_en)        state_nxt = ST_DEACT;
            ST_DEACT:    if (cnt == 4'd0 && !txlinkactiveack) state_nxt = ST_STOP;
            default:     state_nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_STOP;
            cnt     <= 4'd0;
            rr_ptr  <= '0;
            ovf     <= 1'b0;
            flitv_q <= 1'b0;
            flit_q  <= '0;
            areq_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf | ovf_hit;
            flitv_q <= issue;
            areq_q  <= (state_nxt == ST_ACTIVATE) || (state_nxt == ST_RUN);
            if (run_issue) rr_ptr <= grant_idx + IDX_W'(1);
            if (issue)     flit_q <= flit_nxt;
        end
    end

    assign txreq_flitv     = flitv_q;
    assign txreq_flit      = flit_q;
    assign txlinkactivereq = areq_q;
    assign credit_cnt      = cnt;
    assign credit_ovf      = ovf;
endmodule
